// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, register address width
// and the per-entry tag kept by the multi-cycle result FIFO.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } wb_state_e;

  // Data lives in a separate array so the FIFO can follow the arbiter's XLEN parameter.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
  } fifo_tag_t;

  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Multi-cycle result queue with per-entry kill-by-rd and a live-rd CAM for decode hazards.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  push_live,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  head_valid,
  output logic                  head_live,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic                  full,
  output logic                  pend_hit
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_tag_t       tag_q  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == (AW + 1)'(DEPTH));
  assign head_live  = tag_q[rd_ptr_q].live;
  assign head_rd    = tag_q[rd_ptr_q].rd;
  assign head_data  = data_q[rd_ptr_q];

  // Kill first, then pop, then push: a popped slot is cleared so live implies occupied,
  // and a push never lands on the head slot because push is gated by !full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && tag_q[i].live && (tag_q[i].rd == kill_rd)) begin
          tag_q[i].live <= 1'b0;
        end
      end
      if (pop) begin
        tag_q[rd_ptr_q].live <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        tag_q[wr_ptr_q] <= '{live: push_live, rd: push_rd};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_q[i].live && (rd_match(rs1, tag_q[i].rd) || rd_match(rs2, tag_q[i].rd))) begin
        pend_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and queued multi-cycle
// results; pipeline wins, queued results drain in free slots or on a forced stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  output logic                  pipe_stall,
  input  logic [REG_ADDR_W-1:0] rs1_q,
  input  logic [REG_ADDR_W-1:0] rs2_q,
  output logic                  pend_hit,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int unsigned CW = $clog2(STARVE_LIM) + 1;

  wb_state_e             state_q, state_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_d;

  logic                  pipe_wr;
  logic                  mc_push;
  logic                  push_live;
  logic                  pop;
  logic                  head_valid;
  logic                  head_live;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full;

  // A pipeline write during a forced drain is a protocol error and is dropped entirely.
  assign pipe_wr    = (state_q == S_NORM) && pipe_we && (pipe_rd != '0);
  assign mc_ready   = !fifo_full;
  assign mc_push    = mc_valid && mc_ready && (mc_rd != '0);
  assign push_live  = !(pipe_wr && (pipe_rd == mc_rd));
  assign pipe_stall = (state_q == S_FORCE);

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (mc_push),
    .push_live  (push_live),
    .push_rd    (mc_rd),
    .push_data  (mc_data),
    .pop        (pop),
    .kill       (pipe_wr),
    .kill_rd    (pipe_rd),
    .rs1        (rs1_q),
    .rs2        (rs2_q),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .full       (fifo_full),
    .pend_hit   (pend_hit)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pop        = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    unique case (state_q)
      S_NORM: begin
        if (pipe_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = pipe_rd;
          rf_wdata_d = pipe_data;
        end else if (head_valid) begin
          pop = 1'b1;
          if (head_live) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
          end
        end
        if (head_valid && !pop) begin
          if (wait_q == CW'(STARVE_LIM - 1)) begin
            state_d = S_FORCE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wait_d = '0;
        end
      end
      S_FORCE: begin
        pop = head_valid;
        if (head_valid && head_live) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = head_rd;
          rf_wdata_d = head_data;
        end
        wait_d  = '0;
        state_d = S_NORM;
      end
      default: begin
        state_d = S_NORM;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_NORM;
      wait_q   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rf_we    <= rf_we_d;
      rf_waddr <= rf_waddr_d;
      rf_wdata <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, idle drain, starvation, kill, full, x0, reset flush.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        pipe_stall;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        pend_hit;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(
    .DEPTH      (4),
    .STARVE_LIM (8),
    .XLEN       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .mc_valid   (mc_valid),
    .mc_rd      (mc_rd),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .pipe_stall (pipe_stall),
    .rs1_q      (rs1_q),
    .rs2_q      (rs2_q),
    .pend_hit   (pend_hit),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0; rs1_q = '0; rs2_q = '0;

    // 1: reset held with an offered mc result
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44; rs1_q = 5'd4;
    repeat (3) tick();
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_ready", 32'(mc_ready), 32'd1);
    check("rst_pend", 32'(pend_hit), 32'd0);
    rst_n = 1'b1; mc_valid = 1'b0;
    tick();
    check("rst_no_drain", 32'(rf_we), 32'd0);

    // 2: idle drain
    mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'hAAAA_0001; rs1_q = 5'd5;
    tick();
    check("idle_push_we", 32'(rf_we), 32'd0);
    check("idle_pend", 32'(pend_hit), 32'd1);
    mc_valid = 1'b0;
    tick();
    check("idle_we", 32'(rf_we), 32'd1);
    check("idle_addr", 32'(rf_waddr), 32'd5);
    check("idle_data", rf_wdata, 32'hAAAA_0001);
    check("idle_pend_clr", 32'(pend_hit), 32'd0);

    // 3: starvation, head waits 8 busy cycles then one forced drain
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h77; rs1_q = 5'd7;
    tick();
    mc_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("starve_nostall", 32'(pipe_stall), 32'd0);
      check("starve_pipe_addr", 32'(rf_waddr), 32'd3);
    end
    tick();
    check("starve_stall", 32'(pipe_stall), 32'd1);
    check("starve_pend", 32'(pend_hit), 32'd1);
    pipe_rd = 5'd7; pipe_data = 32'hBAD;
    tick();
    check("force_we", 32'(rf_we), 32'd1);
    check("force_addr", 32'(rf_waddr), 32'd7);
    check("force_data", rf_wdata, 32'h77);
    check("force_stall_drop", 32'(pipe_stall), 32'd0);
    pipe_we = 1'b0;
    tick();
    check("force_after", 32'(rf_we), 32'd0);

    // 4: kill by later pipeline write, and same-cycle dead push
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h11; rs1_q = 5'd9;
    tick();
    check("kill_pend_set", 32'(pend_hit), 32'd1);
    mc_valid = 1'b0; pipe_rd = 5'd9; pipe_data = 32'h22;
    tick();
    check("kill_pipe_addr", 32'(rf_waddr), 32'd9);
    check("kill_pipe_data", rf_wdata, 32'h22);
    check("kill_pend_clr", 32'(pend_hit), 32'd0);
    pipe_we = 1'b0;
    tick();
    check("kill_dead_drain", 32'(rf_we), 32'd0);
    pipe_we = 1'b1; pipe_rd = 5'd10; pipe_data = 32'h1010;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0; rs1_q = 5'd0; rs2_q = 5'd10;
    tick();
    check("same_cyc_data", rf_wdata, 32'h1010);
    check("same_cyc_pend", 32'(pend_hit), 32'd0);
    mc_valid = 1'b0; pipe_we = 1'b0;
    tick();
    check("same_cyc_drain", 32'(rf_we), 32'd0);
    rs2_q = 5'd0;

    // 5: fill with pipeline busy, then drain with a held fifth offer
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33; rs1_q = 5'd15;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1'b1; mc_rd = 5'(11 + i); mc_data = 32'h100 + 32'(i);
      tick();
      check("full_ready", 32'(mc_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    mc_rd = 5'd15; mc_data = 32'h10F;
    tick();
    check("full_hold_ready", 32'(mc_ready), 32'd0);
    check("full_no_push", 32'(pend_hit), 32'd0);
    pipe_we = 1'b0;
    tick();
    check("full_pop0_addr", 32'(rf_waddr), 32'd11);
    check("full_pop0_data", rf_wdata, 32'h100);
    check("full_ready_back", 32'(mc_ready), 32'd1);
    tick();
    check("full_pop1_addr", 32'(rf_waddr), 32'd12);
    check("full_push5_pend", 32'(pend_hit), 32'd1);
    check("full_pushpop_ready", 32'(mc_ready), 32'd1);
    mc_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      tick();
      check("full_drain_we", 32'(rf_we), 32'd1);
      check("full_drain_addr", 32'(rf_waddr), 32'(11 + i));
    end
    check("full_last_data", rf_wdata, 32'h10F);

    // 6: x0 handling
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    mc_valid = 1'b1; mc_rd = 5'd20; mc_data = 32'h20;
    tick();
    mc_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
    tick();
    check("x0_drain_we", 32'(rf_we), 32'd1);
    check("x0_drain_addr", 32'(rf_waddr), 32'd20);
    check("x0_drain_data", rf_wdata, 32'h20);
    pipe_we = 1'b0; mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
    tick();
    check("x0_mc_we", 32'(rf_we), 32'd0);
    check("x0_mc_ready", 32'(mc_ready), 32'd1);
    mc_valid = 1'b0;
    tick();
    check("x0_mc_nopush", 32'(rf_we), 32'd0);

    // 7: reset mid-drain discards queued entries
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33; rs1_q = 5'd21;
    mc_valid = 1'b1; mc_rd = 5'd21; mc_data = 32'h21;
    tick();
    mc_rd = 5'd22; mc_data = 32'h22;
    tick();
    mc_valid = 1'b0;
    check("rst2_pend_before", 32'(pend_hit), 32'd1);
    rst_n = 1'b0; pipe_we = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_pend", 32'(pend_hit), 32'd0);
    check("rst2_ready", 32'(mc_ready), 32'd1);
    check("rst2_we", 32'(rf_we), 32'd0);
    tick();
    check("rst2_no_drain", 32'(rf_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
